// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional message lock (contiguous multi-byte messages) enabled by defining UART_ARB_LOCK_EN.
//
// state   | meaning
// IDLE    | arbitrate; req_ready one-hot on the round-robin winner
// START   | one-cycle tx_start pulse with the latched byte
// WAIT_HI | wait for tx_busy to rise; re-pulse after 4 quiet cycles
// WAIT_LO | byte on the line, wait for tx_busy to fall
// GAP     | GAP_CYCLES idle cycles before the next arbitration
module uart_tx_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int GAP_CYCLES = 0,
   localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_start,
   input  logic                          tx_busy,
   output logic [GW-1:0]                 grant_id,
   output logic                          grant_valid
`ifdef UART_ARB_LOCK_EN
   ,
   input  logic [NUM_REQ-1:0]            req_last
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_GAP
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic [GW-1:0]           grant_id_q, grant_id_d;
   logic [GW-1:0]           last_grant_q, last_grant_d;
   logic [7:0]              gap_cnt_q, gap_cnt_d;
   logic [1:0]              miss_cnt_q, miss_cnt_d;

   logic [NUM_REQ-1:0]      elig;
   logic                    win_found;
   logic [GW-1:0]           win_idx;
   logic [GW:0]             cand;
   logic                    grant_now;
   logic [DATA_WIDTH-1:0]   win_data;

`ifdef UART_ARB_LOCK_EN
   logic                    lock_q, lock_d;
   logic [GW-1:0]           lock_id_q, lock_id_d;

   // While locked, only the message owner is eligible, so the search below finds it alone.
   always_comb begin
      elig = req_valid;
      if (lock_q) begin
         elig = req_valid & (NUM_REQ'(1) << lock_id_q);
      end
   end
`else
   assign elig = req_valid;
`endif

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_grant_q} + (GW+1)'(k);
         if (cand >= (GW+1)'(NUM_REQ)) begin
            cand = cand - (GW+1)'(NUM_REQ);
         end
         if (!win_found && elig[cand[GW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[GW-1:0];
         end
      end
   end

   assign grant_now = (state_q == S_IDLE) && !rst && !tx_busy && win_found;
   assign win_data  = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      req_ready = '0;
      if (grant_now) begin
         req_ready = NUM_REQ'(1) << win_idx;
      end
   end

   always_comb begin
      state_d      = state_q;
      tx_data_d    = tx_data_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      gap_cnt_d    = gap_cnt_q;
      miss_cnt_d   = miss_cnt_q;
`ifdef UART_ARB_LOCK_EN
      lock_d       = lock_q;
      lock_id_d    = lock_id_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant_now) begin
               tx_data_d  = win_data;
               grant_id_d = win_idx;
               state_d    = S_START;
`ifdef UART_ARB_LOCK_EN
               if (!lock_q) begin
                  last_grant_d = win_idx;
               end
               lock_d    = !req_last[win_idx];
               lock_id_d = win_idx;
`else
               last_grant_d = win_idx;
`endif
            end
         end
         S_START: begin
            miss_cnt_d = 2'd3;
            state_d    = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (tx_busy) begin
               state_d = S_WAIT_LO;
            end else if (miss_cnt_q == 2'd0) begin
               state_d = S_START;
            end else begin
               miss_cnt_d = miss_cnt_q - 2'd1;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (GAP_CYCLES > 0) begin
                  gap_cnt_d = 8'(GAP_CYCLES - 1);
                  state_d   = S_GAP;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tx_data_q    <= '0;
         grant_id_q   <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
         gap_cnt_q    <= '0;
         miss_cnt_q   <= '0;
`ifdef UART_ARB_LOCK_EN
         lock_q       <= 1'b0;
         lock_id_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         tx_data_q    <= tx_data_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         gap_cnt_q    <= gap_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
`ifdef UART_ARB_LOCK_EN
         lock_q       <= lock_d;
         lock_id_q    <= lock_id_d;
`endif
      end
   end

   assign tx_data     = tx_data_q;
   assign grant_id    = grant_id_q;
   assign tx_start    = (state_q == S_START);
   assign grant_valid = (state_q == S_START) || (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random requesters, a randomly forgetful
// transmitter model, and an event-time reference model of grants and idle windows.
module tb_uart_tx_arbiter;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int GAP = 3;
   localparam int GW  = 2;
   localparam int BIG = 32'h3fff_ffff;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]  req_ready;
   logic [DW-1:0] tx_data;
   logic          tx_start;
   logic          tx_busy = 1'b0;
   logic [GW-1:0] grant_id;
   logic          grant_valid;
`ifdef UART_ARB_LOCK_EN
   logic [N-1:0]  req_last = '1;
`endif

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .grant_id(grant_id), .grant_valid(grant_valid)
`ifdef UART_ARB_LOCK_EN
      , .req_last(req_last)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int id; int data; int cyc;} exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   // monitor: every tx_start must match the oldest expected byte
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL start_missing cyc=%0d got=none exp=start_at_%0d", cyc, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (tx_start) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start cyc=%0d got=start exp=none", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("start_cycle", cyc, e.cyc);
            chk("start_tx_data", int'(tx_data), e.data);
            chk("start_grant_id", int'(grant_id), e.id);
         end
      end
   end

   // reference model state
   logic [DW-1:0] dat [N];
   bit  accepted [N];
   int  last_m, free_at, gv_from, gv_to, busy_lo, busy_hi;
   int  cur_id, cur_data, rst_cycle;
   bit  ignored, rst_pending;
   bit  locked_m;
   int  lock_id_m;

   task automatic pack_data();
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
   endtask

   task automatic drive(input int it);
      bit mode_all = (it >= 1200 && it < 1500);
      if (it == 1800) rst_pending = 1;
      if (cyc == rst_cycle + 2) rst = 1'b0;
      if (rst_pending && cyc > busy_lo && cyc <= busy_hi) begin
         rst         = 1'b1;
         rst_cycle   = cyc;
         rst_pending = 0;
         last_m      = N - 1;
         locked_m    = 0;
         exp_q.delete();
         gv_to       = cyc;
         busy_hi     = cyc;
         free_at     = cyc + 2;
      end
      for (int i = 0; i < N; i++) begin
         if (mode_all) begin
            req_valid[i] = 1'b1;
            dat[i]       = 8'(8'h10 + i);
         end else if (accepted[i]) begin
            req_valid[i] = ($urandom % 2 == 0);
            dat[i]       = 8'($urandom_range(0, 255));
         end else if (req_valid[i]) begin
            if ($urandom % 20 == 0) req_valid[i] = 1'b0;
         end else if ($urandom % 4 == 0) begin
            req_valid[i] = 1'b1;
            dat[i]       = 8'($urandom_range(0, 255));
         end
         accepted[i] = 0;
`ifdef UART_ARB_LOCK_EN
         req_last[i] = ($urandom % 3 != 0);
`endif
      end
      if (cyc == rst_cycle + 2) begin
         req_valid = 4'b1001;
         dat[0]    = 8'($urandom_range(0, 255));
      end
      pack_data();
      tx_busy = (cyc >= busy_lo && cyc <= busy_hi);
   endtask

   task automatic model_step();
      int  exp_ready = 0;
      bit  found = 0;
      int  w = 0;
      int  i;
      bit  exp_gv;
      if (!rst && cyc >= free_at) begin
         for (int k = 1; k <= N; k++) begin
            i = (last_m + k) % N;
            if (!found && req_valid[i] && (!locked_m || i == lock_id_m)) begin
               found = 1;
               w = i;
            end
         end
         if (found) begin
            exp_ready = 1 << w;
            cur_id    = w;
            cur_data  = int'(dat[w]);
            exp_q.push_back('{id: w, data: cur_data, cyc: cyc + 1});
            accepted[w] = 1;
            if (!locked_m) last_m = w;
`ifdef UART_ARB_LOCK_EN
            locked_m  = !req_last[w];
            lock_id_m = w;
`endif
            free_at = BIG;
            gv_from = cyc + 1;
            gv_to   = BIG;
            ignored = 0;
         end
      end
      chk("req_ready", int'(req_ready), exp_ready);
      exp_gv = (cyc >= gv_from && cyc <= gv_to);
      chk("grant_valid", int'(grant_valid), int'(exp_gv));
      if (exp_gv && cyc > gv_from) begin
         chk("tx_data_hold", int'(tx_data), cur_data);
         chk("grant_id_hold", int'(grant_id), cur_id);
      end
      if (cyc == rst_cycle + 1) begin
         chk("rst_tx_start", int'(tx_start), 0);
         chk("rst_tx_data", int'(tx_data), 0);
         chk("rst_grant_id", int'(grant_id), 0);
      end
      if (cyc == rst_cycle + 2) chk("post_rst_ready", int'(req_ready), 1);
      // transmitter model: may miss the first start of a byte
      if (tx_start && !rst) begin
         if (!ignored && $urandom % 4 == 0) begin
            ignored = 1;
            exp_q.push_back('{id: cur_id, data: cur_data, cyc: cyc + 5});
         end else begin
            int len = $urandom_range(1, 10);
            busy_lo = cyc + 1;
            busy_hi = cyc + len;
            gv_to   = cyc + len + 1;
            free_at = cyc + len + GAP + 2;
         end
      end
   endtask

   initial begin
      last_m = N - 1; free_at = BIG; gv_from = BIG; gv_to = BIG;
      busy_lo = 0; busy_hi = -1; rst_cycle = -100; cur_id = 0; cur_data = 0;
      ignored = 0; rst_pending = 0; locked_m = 0; lock_id_m = 0;
      for (int i = 0; i < N; i++) begin
         dat[i] = '0;
         accepted[i] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", int'(req_ready), 0);
      chk("reset_tx_start", int'(tx_start), 0);
      chk("reset_grant_valid", int'(grant_valid), 0);
      chk("reset_tx_data", int'(tx_data), 0);
      chk("reset_grant_id", int'(grant_id), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      free_at = cyc;
      for (int it = 0; it < 2600; it++) begin
         drive(it);
         @(negedge clk);
         model_step();
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      for (int k = 0; k < 200 && !(cyc >= free_at && exp_q.size() == 0); k++) begin
         tx_busy = (cyc >= busy_lo && cyc <= busy_hi);
         @(negedge clk);
         model_step();
         @(posedge clk);
         #1;
      end
      chk("drain_idle", int'(cyc >= free_at), 1);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
